multi_pipe_nbit: RTL and testbench

- Parametrised successor of the 8-bit pipelined shift-and-add multiplier.
- Multiplies two WIDTH-bit operands per transaction, each transaction selecting signed or unsigned mode.
- Pipeline: input register, binary adder tree of partial products, output register.
- Fixed latency, one result per cycle, valid/ready backpressure on both sides.
- Sits between operand-issuing datapath logic and result consumers in the arithmetic library.

---
 rtl/multi_pipe_nbit.sv | 104 ++++++++++
 tb/tb_multi_pipe_nbit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pipe_nbit.sv
// Pipelined WIDTH x WIDTH multiplier with per-transaction signed/unsigned mode.
// Input register, registered binary adder tree of partial products, output register.
module multi_pipe_nbit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mul_en_in,
  output logic               mul_rdy_in,
  input  logic               mul_signed,
  input  logic [WIDTH-1:0]   mul_a,
  input  logic [WIDTH-1:0]   mul_b,
  output logic               mul_en_out,
  input  logic               mul_rdy_out,
  output logic [2*WIDTH-1:0] mul_out
);

  localparam int TREE_STAGES = $clog2(WIDTH);
  localparam int PW          = 2 * WIDTH;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sgn;
  logic [TREE_STAGES:0] r_vld;
  logic               r_vld_out;
  logic [PW-1:0]      r_out;
  logic [PW-1:0]      r_lvl [TREE_STAGES][WIDTH];

  logic               w_adv;
  logic [PW-1:0]      w_a_ext;
  logic [PW-1:0]      w_row;
  logic [PW-1:0]      w_pad [TREE_STAGES][2*WIDTH];
  logic [PW-1:0]      w_nxt [TREE_STAGES][WIDTH];

  assign w_adv      = !r_vld_out || mul_rdy_out;
  assign mul_rdy_in = w_adv;
  assign mul_en_out = r_vld_out;
  assign mul_out    = r_out;

  assign w_a_ext = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};

  // Each level sees a zero-padded copy of the level below, so an odd leftover
  // is simply added to zero and slots past the live count stay zero.
  always_comb begin
    w_row = '0;
    for (int l = 0; l < TREE_STAGES; l++) begin
      for (int k = 0; k < 2*WIDTH; k++) begin
        w_pad[l][k] = '0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_row = r_b[i] ? (w_a_ext << i) : '0;
      if (r_sgn && (i == WIDTH-1)) begin
        w_row = -w_row;
      end
      w_pad[0][i] = w_row;
    end
    for (int l = 1; l < TREE_STAGES; l++) begin
      for (int k = 0; k < WIDTH; k++) begin
        w_pad[l][k] = r_lvl[l-1][k];
      end
    end
    for (int l = 0; l < TREE_STAGES; l++) begin
      for (int j = 0; j < WIDTH; j++) begin
        w_nxt[l][j] = w_pad[l][2*j] + w_pad[l][2*j+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sgn     <= 1'b0;
      r_vld     <= '0;
      r_vld_out <= 1'b0;
      r_out     <= '0;
      for (int l = 0; l < TREE_STAGES; l++) begin
        for (int j = 0; j < WIDTH; j++) begin
          r_lvl[l][j] <= '0;
        end
      end
    end else if (w_adv) begin
      if (TREE_STAGES > 0) begin
        r_vld <= {r_vld[TREE_STAGES-1:0], mul_en_in};
      end
      r_vld_out <= r_vld[TREE_STAGES];
      if (mul_en_in) begin
        r_a   <= mul_a;
        r_b   <= mul_b;
        r_sgn <= mul_signed;
      end
      for (int l = 0; l < TREE_STAGES; l++) begin
        if (r_vld[l]) begin
          r_lvl[l] <= w_nxt[l];
        end
      end
      if (r_vld[TREE_STAGES]) begin
        r_out <= r_lvl[TREE_STAGES-1][0];
      end
    end
  end

endmodule

// File: tb/tb_multi_pipe_nbit.sv
// Directed bench for multi_pipe_nbit at WIDTH=8, 4 and 16; each test task
// drives its own stimulus and compares against hand values or a product model.
module tb_multi_pipe_nbit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic en8, sg8, ro8, rdy8, vo8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;
  logic en4, sg4, ro4, rdy4, vo4;
  logic [3:0]  a4, b4;
  logic [7:0]  out4;
  logic en16, sg16, ro16, rdy16, vo16;
  logic [15:0] a16, b16;
  logic [31:0] out16;

  multi_pipe_nbit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .mul_en_in(en8), .mul_rdy_in(rdy8), .mul_signed(sg8),
    .mul_a(a8), .mul_b(b8), .mul_en_out(vo8), .mul_rdy_out(ro8), .mul_out(out8));
  multi_pipe_nbit #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .mul_en_in(en4), .mul_rdy_in(rdy4), .mul_signed(sg4),
    .mul_a(a4), .mul_b(b4), .mul_en_out(vo4), .mul_rdy_out(ro4), .mul_out(out4));
  multi_pipe_nbit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .mul_en_in(en16), .mul_rdy_in(rdy16), .mul_signed(sg16),
    .mul_a(a16), .mul_b(b16), .mul_en_out(vo16), .mul_rdy_out(ro16), .mul_out(out16));

  int          sel;
  logic        vo_m, rdy_m;
  logic [63:0] out_m;

  always_comb begin
    vo_m  = vo8;
    rdy_m = rdy8;
    out_m = {48'b0, out8};
    if (sel == 1) begin
      vo_m  = vo4;
      rdy_m = rdy4;
      out_m = {56'b0, out4};
    end else if (sel == 2) begin
      vo_m  = vo16;
      rdy_m = rdy16;
      out_m = {32'b0, out16};
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] st_a [$];
  logic [31:0] st_b [$];
  bit          st_s [$];
  logic [63:0] got [$];
  int          got_cyc [$];
  int          stall_bad;

  function automatic int wof(input int s);
    return (s == 1) ? 4 : ((s == 2) ? 16 : 8);
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input bit s);
    longint      x, y;
    logic [63:0] p;
    x = longint'({32'b0, a}) & ((longint'(1) << w) - 1);
    y = longint'({32'b0, b}) & ((longint'(1) << w) - 1);
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p = 64'(x * y);
    return p & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  task automatic drv(input int s, input bit en, input logic [31:0] a, input logic [31:0] b,
                     input bit sg, input bit ro);
    case (s)
      1:       begin en4  = en; a4  = a[3:0];  b4  = b[3:0];  sg4  = sg; ro4  = ro; end
      2:       begin en16 = en; a16 = a[15:0]; b16 = b[15:0]; sg16 = sg; ro16 = ro; end
      default: begin en8  = en; a8  = a[7:0];  b8  = b[7:0];  sg8  = sg; ro8  = ro; end
    endcase
  endtask

  // Streams st_* into DUT s, holding mul_rdy_out low for stall_len cycles from
  // loop cycle stall_at; records consumed results and their loop cycle.
  task automatic stream(input int s, input int stall_at, input int stall_len, input int max_cyc);
    int          idx;
    bit          en, ro_now;
    logic [63:0] held;
    idx = 0;
    held = '0;
    sel = s;
    got.delete();
    got_cyc.delete();
    stall_bad = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      ro_now = !(c >= stall_at && c < stall_at + stall_len);
      en = (idx < st_a.size());
      if (en) drv(s, 1'b1, st_a[idx], st_b[idx], st_s[idx], ro_now);
      else    drv(s, 1'b0, '0, '0, 1'b0, ro_now);
      #1;
      if (c == stall_at) held = out_m;
      if (!ro_now && (rdy_m || !vo_m || out_m !== held)) stall_bad++;
      if (vo_m && ro_now) begin
        got.push_back(out_m);
        got_cyc.push_back(c);
      end
      if (en && rdy_m) idx++;
      if (got.size() == st_a.size()) break;
    end
    drv(s, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic load1(input logic [31:0] a, input logic [31:0] b, input bit s);
    st_a.push_back(a);
    st_b.push_back(b);
    st_s.push_back(s);
  endtask

  task automatic clear_stim;
    st_a.delete();
    st_b.delete();
    st_s.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (vo8 !== 1'b0 || out8 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_w8: en_out=%b out=%h, required 0/0000", vo8, out8);
    end
    n_checks++;
    if (vo4 !== 1'b0 || vo16 !== 1'b0 || out4 !== 8'h0 || out16 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_w4_w16: en_out=%b/%b out=%h/%h, required 0", vo4, vo16, out4, out16);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rdy8 !== 1'b1 || vo8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy_in=%b en_out=%b, required 1/0", rdy8, vo8);
    end
  endtask

  task automatic test_single(input logic [7:0] a, input logic [7:0] b, input bit s,
                             input logic [15:0] exp, input string name);
    clear_stim();
    load1({24'b0, a}, {24'b0, b}, s);
    stream(0, -100, 0, 30);
    n_checks++;
    if (got.size() != 1) begin
      n_fail++;
      $display("FAIL %s_count: got %0d results, required 1", name, got.size());
    end else begin
      n_checks++;
      if (got[0] !== {48'b0, exp}) begin
        n_fail++;
        $display("FAIL %s_value: got %h, required %h", name, got[0][15:0], exp);
      end
      n_checks++;
      if (got_cyc[0] != 5) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d cycles, required 5", name, got_cyc[0]);
      end
    end
  endtask

  task automatic test_unsigned;
    test_single(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255");
  endtask

  task automatic test_signed;
    test_single(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_sq");
    test_single(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1x1");
    // 127 * -127 = -16129
    test_single(8'h7F, 8'h81, 1'b1, 16'hC0FF, "s_127xm127");
  endtask

  task automatic test_back_to_back;
    clear_stim();
    for (int i = 0; i < 16; i++) load1(32'(i), 32'(255 - i), bit'(i % 2));
    stream(0, -100, 0, 40);
    n_checks++;
    if (got.size() != 16) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 16", got.size());
    end else begin
      n_checks++;
      if (got_cyc[0] != 5) begin
        n_fail++;
        $display("FAIL b2b_first_cycle: got %0d, required 5", got_cyc[0]);
      end
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (got[i] !== ref_mul(8, st_a[i], st_b[i], st_s[i])) begin
          n_fail++;
          $display("FAIL b2b_value[%0d]: got %h, required %h", i, got[i],
                   ref_mul(8, st_a[i], st_b[i], st_s[i]));
        end
        n_checks++;
        if (got_cyc[i] != got_cyc[0] + i) begin
          n_fail++;
          $display("FAIL b2b_gap[%0d]: got cycle %0d, required %0d", i, got_cyc[i], got_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    clear_stim();
    for (int i = 0; i < 8; i++) load1(32'(17*i + 3), 32'(200 - 13*i), bit'((i % 2) == 0));
    stream(0, 6, 3, 40);
    n_checks++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_stall: %0d stalled cycles with rdy_in high or output moving, required 0", stall_bad);
    end
    n_checks++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got[i] !== ref_mul(8, st_a[i], st_b[i], st_s[i])) begin
          n_fail++;
          $display("FAIL bp_value[%0d]: got %h, required %h", i, got[i],
                   ref_mul(8, st_a[i], st_b[i], st_s[i]));
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    int stray;
    sel = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 3) drv(0, 1'b1, 32'(c + 5), 32'(c + 9), 1'b0, 1'b1);
      else       drv(0, 1'b0, '0, '0, 1'b0, 1'b1);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (vo8 !== 1'b1 || out8 !== 16'd45) begin
      n_fail++;
      $display("FAIL rst_mid_pre: en_out=%b out=%h, required 1/002d", vo8, out8);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vo8 !== 1'b0 || out8 !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: en_out=%b out=%h, required 0/0000", vo8, out8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (vo8 !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0 || out8 !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: %0d valid cycles, out=%h, required 0/0000", stray, out8);
    end
  endtask

  task automatic test_sweep(input int s, input logic [31:0] ca, input logic [31:0] cb,
                            input logic [63:0] cexp, input int lat, input string name);
    int w;
    w = wof(s);
    stream(s, -100, 0, st_a.size() + 40);
    n_checks++;
    if (got.size() != st_a.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d results, required %0d", name, got.size(), st_a.size());
    end else begin
      n_checks++;
      if (got_cyc[0] != lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d, required %0d", name, got_cyc[0], lat);
      end
      n_checks++;
      if (got[0] !== cexp) begin
        n_fail++;
        $display("FAIL %s_corner: a=%h b=%h got %h, required %h", name, ca, cb, got[0], cexp);
      end
      for (int i = 1; i < got.size(); i++) begin
        n_checks++;
        if (got[i] !== ref_mul(w, st_a[i], st_b[i], st_s[i])) begin
          n_fail++;
          $display("FAIL %s_value[%0d]: a=%h b=%h s=%0d got %h, required %h", name, i,
                   st_a[i], st_b[i], st_s[i], got[i], ref_mul(w, st_a[i], st_b[i], st_s[i]));
        end
      end
    end
  endtask

  task automatic test_width4;
    clear_stim();
    load1(32'h8, 32'h8, 1'b1);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) load1(32'(a), 32'(b), bit'(s));
    test_sweep(1, 32'h8, 32'h8, 64'h40, 4, "w4");
  endtask

  task automatic test_width16;
    logic [31:0] corners [6];
    corners[0] = 32'h0000; corners[1] = 32'h0001; corners[2] = 32'h7FFF;
    corners[3] = 32'h8000; corners[4] = 32'h8001; corners[5] = 32'hFFFF;
    clear_stim();
    load1(32'h8000, 32'h8000, 1'b1);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) load1(corners[i], corners[j], bit'(s));
    for (int i = 0; i < 24; i++)
      load1(32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), bit'(i % 2));
    test_sweep(2, 32'h8000, 32'h8000, 64'h4000_0000, 6, "w16");
  endtask

  initial begin
    sel = 0;
    drv(0, 1'b0, '0, '0, 1'b0, 1'b1);
    drv(1, 1'b0, '0, '0, 1'b0, 1'b1);
    drv(2, 1'b0, '0, '0, 1'b0, 1'b1);
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_width4();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
